ofmap_streamer: RTL and testbench

- Output-side companion to `conv`.
- When `done_conv` rises, the block captures the parallel `ofmap` array into a shadow buffer. It then streams the pixels out one per handshake in raster order (row 0 col 0 first) over a valid/ready interface, with end-of-row and end-of-frame markers.
- It sits between `conv` and any downstream consumer (pooling stage, DMA, or bench sink). Because of the shadow buffer, `conv` may start its next frame while the previous one is still draining.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/ofmap_streamer_if.sv | 36 +++
 rtl/ofmap_streamer_raster_counter.sv | 51 +++++
 rtl/ofmap_streamer.sv | 127 ++++++++++++
 tb/tb_ofmap_streamer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the CNN datapath blocks.
//   DEFAULT_DATA_WIDTH : default pixel width
//   strm_state_t       : state encoding for streaming FSMs (IDLE, STREAM)
//   cnt_width()        : counter width for an index range 0..n-1, never below 1
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } strm_state_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ofmap_streamer_if.sv
// ofmap_streamer_if
// Pixel stream with valid/ready handshake and row/frame markers.
//   m_valid : pixel on m_data is valid (producer)
//   m_ready : consumer accepts (consumer)
//   m_data  : pixel value (producer)
//   m_eol   : pixel is the last column of its row (producer)
//   m_last  : pixel is the last of the frame (producer)
interface ofmap_streamer_if
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_eol;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_eol,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_eol,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/ofmap_streamer_raster_counter.sv
// raster_counter
// Row/column raster position counter.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous return to (0,0), wins over en
//   en         : advance one position
//   row, col   : current position
//   eol        : col is the last column
//   last       : position is the last of the frame
module raster_counter
  import cnn_pkg::*;
#(
  parameter int ROWS = 128,
  parameter int COLS = 128,
  localparam int RW = cnt_width(ROWS),
  localparam int CW = cnt_width(COLS)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          eol,
  output logic          last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  assign eol  = (col == COL_MAX);
  assign last = eol && (row == ROW_MAX);

  // Past the final position both counters wrap to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (eol) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ofmap_streamer.sv
// ofmap_streamer
// Captures a parallel feature map on the rising edge of done_conv and
// streams it out in raster order, one pixel per handshake.
//   clk, reset : clock, asynchronous active-low reset
//   done_conv  : frame-ready level from conv; rising edge starts a frame
//   ofmap      : parallel feature map [row][col]
//   m          : pixel stream (master side)
//   busy       : a captured frame is still draining
//   frame_done : one-cycle pulse after the final transfer of a frame
//   overrun    : sticky; a frame arrived while busy and was dropped
module ofmap_streamer
  import cnn_pkg::*;
#(
  parameter int OFMAP_ROWS = 128,
  parameter int OFMAP_COLS = 128,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  done_conv,
  input  logic [DATA_WIDTH-1:0] ofmap [0:OFMAP_ROWS-1][0:OFMAP_COLS-1],
  ofmap_streamer_if.master      m,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int RW = cnt_width(OFMAP_ROWS);
  localparam int CW = cnt_width(OFMAP_COLS);

  strm_state_t           state, state_nxt;
  logic                  done_q, armed;
  logic                  start, xfer, final_xfer;
  logic                  capture, clear_cnt, set_overrun;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  cnt_eol, cnt_last;
  logic [DATA_WIDTH-1:0] shadow [0:OFMAP_ROWS-1][0:OFMAP_COLS-1];

  // armed stays low after reset until done_conv has been seen low, so a
  // level left high across reset cannot masquerade as a new frame.
  assign start      = done_conv && !done_q && armed;
  assign xfer       = (state == STREAM) && m.m_ready;
  assign final_xfer = xfer && cnt_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      done_q <= done_conv;
      if (!done_conv) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A start coinciding with the final transfer chains straight into the
  // next frame; any other start during STREAM is dropped and flagged.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    clear_cnt   = 1'b0;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          clear_cnt = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (final_xfer) begin
          if (start) begin
            capture   = 1'b1;
            clear_cnt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (start) begin
          set_overrun = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel storage only; outputs are gated by state, so no reset is needed.
  always_ff @(posedge clk) begin
    if (capture) shadow <= ofmap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= final_xfer;
      if (set_overrun) overrun <= 1'b1;
    end
  end

  raster_counter #(
    .ROWS (OFMAP_ROWS),
    .COLS (OFMAP_COLS)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .en    (xfer),
    .row   (row),
    .col   (col),
    .eol   (cnt_eol),
    .last  (cnt_last)
  );

  assign busy     = (state == STREAM);
  assign m.m_valid = (state == STREAM);
  assign m.m_data  = (state == STREAM) ? shadow[row][col] : '0;
  assign m.m_eol   = (state == STREAM) && cnt_eol;
  assign m.m_last  = (state == STREAM) && cnt_last;

endmodule

// File: tb/tb_ofmap_streamer.sv
// tb_ofmap_streamer
// Directed bench for ofmap_streamer with a 3x4 map, ofmap[r][c] = r*16+c.
module tb_ofmap_streamer;

  logic       clk;
  logic       reset;
  logic       done_conv;
  logic [7:0] ofmap [0:2][0:3];
  logic       busy;
  logic       frame_done;
  logic       overrun;

  int vec_count;
  int miscompares;

  ofmap_streamer_if #(.DATA_WIDTH(8)) sif ();

  ofmap_streamer #(
    .OFMAP_ROWS (3),
    .OFMAP_COLS (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .done_conv  (done_conv),
    .ofmap      (ofmap),
    .m          (sif),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int base, input int k);
    int v;
    v = (k / 4) * 16 + (k % 4) + base;
    return v[7:0];
  endfunction

  task automatic load_map(input int base);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        ofmap[r][c] = pix(base, r * 4 + c);
  endtask

  task automatic fill_ff();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        ofmap[r][c] = 8'hFF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic done, input logic rdy);
    done_conv   = done;
    sif.m_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks pixels first..last_idx of a frame, checking each cycle; with
  // stall set, m_ready follows 1,0,0,1,0,0...
  task automatic drain(input int base, input int first, input int last_idx, input bit stall);
    int   k;
    int   p;
    logic rdy;
    k = first;
    p = 0;
    while (k <= last_idx && p < 100) begin
      rdy = stall ? ((p % 3) == 0) : 1'b1;
      sif.m_ready = rdy;
      checkOutput($sformatf("valid[%0d]", k), sif.m_valid, 1);
      checkOutput($sformatf("data[%0d]", k), sif.m_data, pix(base, k));
      checkOutput($sformatf("eol[%0d]", k), sif.m_eol, (k % 4) == 3);
      checkOutput($sformatf("last[%0d]", k), sif.m_last, k == 11);
      if (p != 0) checkOutput($sformatf("fdone_mid[%0d]", k), frame_done, 0);
      tick();
      p++;
      if (rdy) k++;
    end
    checkOutput("drain_count", k, last_idx + 1);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, sif.m_valid, 0);
    checkOutput({tag, "_data"}, sif.m_data, 0);
    checkOutput({tag, "_eol"}, sif.m_eol, 0);
    checkOutput({tag, "_last"}, sif.m_last, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_fdone"}, frame_done, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    reset       = 1'b1;
    load_map(0);
    applyStimulus(0, 0);
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    #1 reset = 1'b1;
    tick();

    $display("[TB] basic drain");
    applyStimulus(1, 1);
    tick();
    checkOutput("basic_busy", busy, 1);
    drain(0, 0, 11, 0);
    checkOutput("basic_fdone", frame_done, 1);
    checkOutput("basic_valid_end", sif.m_valid, 0);
    checkOutput("basic_busy_end", busy, 0);
    tick();
    checkOutput("basic_fdone_off", frame_done, 0);
    checkOutput("basic_held_idle", busy, 0);

    $display("[TB] backpressure");
    applyStimulus(0, 1);
    tick();
    applyStimulus(1, 1);
    tick();
    drain(0, 0, 11, 1);
    checkOutput("bp_fdone", frame_done, 1);
    checkOutput("bp_busy_end", busy, 0);

    $display("[TB] shadow isolation");
    applyStimulus(0, 1);
    tick();
    applyStimulus(1, 1);
    tick();
    fill_ff();
    drain(0, 0, 11, 0);
    checkOutput("shadow_fdone", frame_done, 1);
    checkOutput("shadow_overrun", overrun, 0);
    load_map(0);

    $display("[TB] overrun");
    applyStimulus(0, 1);
    tick();
    applyStimulus(1, 1);
    tick();
    applyStimulus(0, 1);
    drain(0, 0, 4, 0);
    applyStimulus(1, 1);
    drain(0, 5, 11, 0);
    checkOutput("ovr_flag", overrun, 1);
    checkOutput("ovr_fdone", frame_done, 1);
    checkOutput("ovr_busy_end", busy, 0);
    tick();
    checkOutput("ovr_fdone_off", frame_done, 0);
    checkOutput("ovr_sticky", overrun, 1);
    checkOutput("ovr_idle", busy, 0);

    $display("[TB] back-to-back");
    applyStimulus(0, 1);
    tick();
    applyStimulus(1, 1);
    tick();
    applyStimulus(0, 1);
    drain(0, 0, 10, 0);
    load_map(100);
    applyStimulus(1, 1);
    checkOutput("b2b_pre_data", sif.m_data, 35);
    checkOutput("b2b_pre_last", sif.m_last, 1);
    tick();
    checkOutput("b2b_fdone", frame_done, 1);
    checkOutput("b2b_valid", sif.m_valid, 1);
    checkOutput("b2b_data", sif.m_data, 100);
    checkOutput("b2b_busy", busy, 1);
    drain(100, 0, 11, 0);
    checkOutput("b2b_fdone2", frame_done, 1);
    checkOutput("b2b_valid_end", sif.m_valid, 0);
    tick();
    checkOutput("b2b_fdone2_off", frame_done, 0);
    checkOutput("b2b_idle", busy, 0);

    $display("[TB] async reset mid-frame");
    applyStimulus(0, 1);
    tick();
    load_map(0);
    applyStimulus(1, 1);
    tick();
    drain(0, 0, 5, 0);
    #2 reset = 1'b0;
    #1 check_all_zero("arst");
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("arst_held_busy", busy, 0);
    checkOutput("arst_held_valid", sif.m_valid, 0);
    applyStimulus(0, 1);
    tick();
    applyStimulus(1, 1);
    tick();
    checkOutput("arst_restart_busy", busy, 1);
    drain(0, 0, 11, 0);
    checkOutput("arst_fdone", frame_done, 1);
    tick();
    checkOutput("arst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
